// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the MIPS IF stage.
// Build option: IF_FETCH_ALIGN_CHK_EN enables the misaligned-fetch check.
package if_fetch_pkg;

    localparam int BR_WD       = 33;
    localparam int IF_TO_ID_WD = 33;
    localparam int STALL_WD    = 2;

    typedef logic [STALL_WD-1:0] stall_bus_t;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        IF_FETCH_BOOT = 2'd0,
        IF_FETCH_RUN  = 2'd1,
        IF_FETCH_HOLD = 2'd2
    } if_fetch_state_e;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_fetch_if.sv
// IF-stage bus bundle: stall/redirect inputs, instruction SRAM port and IF->ID outputs.
// Build option: IF_FETCH_ALIGN_CHK_EN adds the if_adel flag.
interface if_fetch_if;
    import if_fetch_pkg::*;

    stall_bus_t             stall;
    logic [BR_WD-1:0]       br_bus;
    logic [31:0]            inst_sram_rdata;
    logic                   inst_sram_en;
    logic [3:0]             inst_sram_wen;
    logic [31:0]            inst_sram_addr;
    logic [31:0]            inst_sram_wdata;
    logic [IF_TO_ID_WD-1:0] if_to_id_bus;
    logic [31:0]            inst_to_id;
`ifdef IF_FETCH_ALIGN_CHK_EN
    logic                   if_adel;
`endif

    modport master (
        input  stall, br_bus, inst_sram_rdata,
        output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        output if_to_id_bus, inst_to_id
`ifdef IF_FETCH_ALIGN_CHK_EN
        , output if_adel
`endif
    );

    modport slave (
        output stall, br_bus, inst_sram_rdata,
        input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
        input  if_to_id_bus, inst_to_id
`ifdef IF_FETCH_ALIGN_CHK_EN
        , input if_adel
`endif
    );

endinterface

// File: rtl/if_fetch_inst_hold.sv
// One-entry instruction hold buffer: keeps the SRAM word decode was handed
// when IF/ID stalled, so decode sees a stable instruction.
module if_inst_hold (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    input  logic        release_i,
    input  logic [31:0] rdata_i,
    output logic        hold_valid_o,
    output logic [31:0] inst_o
);

    logic        hold_valid_q;
    logic [31:0] hold_inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid_q <= 1'b0;
            hold_inst_q  <= 32'h0;
        end else if (capture_i) begin
            hold_valid_q <= 1'b1;
            hold_inst_q  <= rdata_i;
        end else if (release_i) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign hold_valid_o = hold_valid_q;
    assign inst_o       = hold_valid_q ? hold_inst_q : rdata_i;

endmodule

// File: rtl/if_fetch.sv
// MIPS IF stage: PC register, instruction SRAM request, stalled-redirect latch.
// Build option: IF_FETCH_ALIGN_CHK_EN flags misaligned fetches and suppresses them.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          HOLD_DEPTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    if_fetch_if.master  bus
);

    if (HOLD_DEPTH != 1) begin : g_bad_hold_depth
        $error("if_fetch: HOLD_DEPTH must be 1");
    end

    if_fetch_state_e state_q;
    logic [31:0]     pc_q, pc_d;
    logic            ce_q;
    logic            pend_valid_q;
    logic [31:0]     pend_addr_q;

    logic            br_e;
    logic [31:0]     br_addr;
    logic            pc_stop, id_stop;
    logic            hold_valid;
    logic            hold_capture, hold_release;
    logic [31:0]     inst_held;

    assign br_e    = bus.br_bus[32];
    assign br_addr = bus.br_bus[31:0];
    assign pc_stop = (bus.stall[0] == STOP);
    assign id_stop = (bus.stall[1] == STOP);

    // A redirect parked during a stall outranks anything decode sends later.
    always_comb begin
        pc_d = pc_plus4(pc_q);
        if (pend_valid_q)
            pc_d = pend_addr_q;
        else if (br_e)
            pc_d = br_addr;
    end

    assign hold_capture = (state_q == IF_FETCH_RUN) && pc_stop && id_stop && !hold_valid;
    assign hold_release = (state_q == IF_FETCH_HOLD) && !id_stop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IF_FETCH_BOOT;
            pc_q         <= RESET_PC;
            ce_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'h0;
        end else begin
            case (state_q)
                IF_FETCH_BOOT: begin
                    state_q <= IF_FETCH_RUN;
                    ce_q    <= 1'b1;
                    pc_q    <= pc_d;
                end
                IF_FETCH_RUN, IF_FETCH_HOLD: begin
                    if (!pc_stop) begin
                        pc_q         <= pc_d;
                        ce_q         <= 1'b1;
                        pend_valid_q <= 1'b0;
                    end else if (br_e) begin
                        pend_valid_q <= 1'b1;
                        pend_addr_q  <= br_addr;
                    end
                    if (hold_capture)
                        state_q <= IF_FETCH_HOLD;
                    else if (hold_release)
                        state_q <= IF_FETCH_RUN;
                end
                default: state_q <= IF_FETCH_BOOT;
            endcase
        end
    end

    if_inst_hold u_hold (
        .clk          (clk),
        .rst          (rst),
        .capture_i    (hold_capture),
        .release_i    (hold_release),
        .rdata_i      (bus.inst_sram_rdata),
        .hold_valid_o (hold_valid),
        .inst_o       (inst_held)
    );

    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.if_to_id_bus    = {ce_q, pc_q};

`ifdef IF_FETCH_ALIGN_CHK_EN
    logic adel;
    assign adel             = ce_q & (pc_q[1:0] != 2'b00);
    assign bus.if_adel      = adel;
    assign bus.inst_sram_en = ce_q & ~adel;
    assign bus.inst_to_id   = adel ? 32'h0 : inst_held;
`else
    assign bus.inst_sram_en = ce_q;
    assign bus.inst_to_id   = inst_held;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch.
// Build option: IF_FETCH_ALIGN_CHK_EN switches the misaligned-fetch expectations.
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   passed = 0;
    int   total  = 0;

    if_fetch_if bus ();

    if_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.stall = 2'b00;
        bus.br_bus = '0;
        bus.inst_sram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.inst_sram_addr !== 32'hBFBF_FFFC) $display("FAIL rst_addr: got %h want bfbffffc", bus.inst_sram_addr); else passed++;
        total++; if (bus.inst_sram_en !== 1'b0) $display("FAIL rst_en: got %b want 0", bus.inst_sram_en); else passed++;
        total++; if (bus.if_to_id_bus[32] !== 1'b0) $display("FAIL rst_ce: got %b want 0", bus.if_to_id_bus[32]); else passed++;
        total++; if (bus.inst_to_id !== 32'h0) $display("FAIL rst_inst: got %h want 0", bus.inst_to_id); else passed++;
        total++; if ({bus.inst_sram_wen, bus.inst_sram_wdata} !== 36'h0) $display("FAIL rst_wr: got %h want 0", {bus.inst_sram_wen, bus.inst_sram_wdata}); else passed++;
    endtask

    task automatic test_sequential_fetch();
        rst = 1'b1;
        #1;
        total++; if (bus.inst_sram_addr !== 32'hBFBF_FFFC || bus.inst_sram_en !== 1'b0) $display("FAIL seq0: got %h/%b want bfbffffc/0", bus.inst_sram_addr, bus.inst_sram_en); else passed++;
        tick();
        total++; if (bus.if_to_id_bus !== {1'b1, 32'hBFC0_0000} || bus.inst_sram_en !== 1'b1) $display("FAIL seq1: got %h/%b want 1bfc00000/1", bus.if_to_id_bus, bus.inst_sram_en); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0004) $display("FAIL seq2: got %h want bfc00004", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0008) $display("FAIL seq3: got %h want bfc00008", bus.inst_sram_addr); else passed++;
    endtask

    task automatic test_branch();
        bus.br_bus = {1'b1, 32'hBFC0_0100};
        tick();
        bus.br_bus = '0;
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0100) $display("FAIL br_target: got %h want bfc00100", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0104) $display("FAIL br_next: got %h want bfc00104", bus.inst_sram_addr); else passed++;
    endtask

    task automatic test_hold();
        bus.stall = 2'b11;
        bus.inst_sram_rdata = 32'h3C01_1234;
        tick();
        bus.inst_sram_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (bus.inst_to_id !== 32'h3C01_1234) $display("FAIL hold_inst1: got %h want 3c011234", bus.inst_to_id); else passed++;
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0104) $display("FAIL hold_pc1: got %h want bfc00104", bus.inst_sram_addr); else passed++;
        tick();
        tick();
        total++; if (bus.inst_to_id !== 32'h3C01_1234) $display("FAIL hold_inst3: got %h want 3c011234", bus.inst_to_id); else passed++;
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0104) $display("FAIL hold_pc3: got %h want bfc00104", bus.inst_sram_addr); else passed++;
        bus.stall = 2'b00;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0108) $display("FAIL hold_rel_pc: got %h want bfc00108", bus.inst_sram_addr); else passed++;
        total++; if (bus.inst_to_id !== 32'hDEAD_BEEF) $display("FAIL hold_rel_inst: got %h want deadbeef", bus.inst_to_id); else passed++;
    endtask

    task automatic test_pend_redirect();
        bus.stall = 2'b01;
        bus.br_bus = {1'b1, 32'hBFC0_0200};
        tick();
        bus.br_bus = {1'b1, 32'hBFC0_0300};
        tick();
        bus.br_bus = '0;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0108) $display("FAIL pend_frozen: got %h want bfc00108", bus.inst_sram_addr); else passed++;
        bus.stall = 2'b00;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0300) $display("FAIL pend_latest: got %h want bfc00300", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0304) $display("FAIL pend_cleared: got %h want bfc00304", bus.inst_sram_addr); else passed++;
        // Release and a fresh branch together: the parked redirect wins.
        bus.stall = 2'b01;
        bus.br_bus = {1'b1, 32'hBFC0_0400};
        tick();
        bus.stall = 2'b00;
        bus.br_bus = {1'b1, 32'hBFC0_0500};
        tick();
        bus.br_bus = '0;
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0400) $display("FAIL pend_vs_br: got %h want bfc00400", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0404) $display("FAIL pend_vs_br_next: got %h want bfc00404", bus.inst_sram_addr); else passed++;
    endtask

    task automatic test_wrap();
        bus.br_bus = {1'b1, 32'hFFFF_FFFC};
        tick();
        bus.br_bus = '0;
        total++; if (bus.inst_sram_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got %h want fffffffc", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'h0000_0000) $display("FAIL wrap_zero: got %h want 00000000", bus.inst_sram_addr); else passed++;
    endtask

    task automatic test_misalign();
        bus.inst_sram_rdata = 32'h1234_5678;
        bus.br_bus = {1'b1, 32'hBFC0_0102};
        tick();
        bus.br_bus = '0;
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0102) $display("FAIL mis_addr: got %h want bfc00102", bus.inst_sram_addr); else passed++;
`ifdef IF_FETCH_ALIGN_CHK_EN
        total++; if (bus.if_adel !== 1'b1 || bus.inst_sram_en !== 1'b0) $display("FAIL mis_adel: got adel=%b en=%b want 1/0", bus.if_adel, bus.inst_sram_en); else passed++;
        total++; if (bus.inst_to_id !== 32'h0) $display("FAIL mis_nop: got %h want 0", bus.inst_to_id); else passed++;
`else
        total++; if (bus.inst_sram_en !== 1'b1) $display("FAIL mis_en: got %b want 1", bus.inst_sram_en); else passed++;
        total++; if (bus.inst_to_id !== 32'h1234_5678) $display("FAIL mis_inst: got %h want 12345678", bus.inst_to_id); else passed++;
`endif
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0106) $display("FAIL mis_advance: got %h want bfc00106", bus.inst_sram_addr); else passed++;
    endtask

    task automatic test_reset_mid_hold();
        bus.stall = 2'b11;
        bus.inst_sram_rdata = 32'hAAAA_5555;
        bus.br_bus = {1'b1, 32'hBFC0_0600};
        tick();
        bus.br_bus = '0;
        bus.inst_sram_rdata = 32'h0;
        #1;
        total++; if (bus.inst_to_id !== 32'hAAAA_5555) $display("FAIL rmh_held: got %h want aaaa5555", bus.inst_to_id); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus.inst_sram_addr !== 32'hBFBF_FFFC || bus.inst_sram_en !== 1'b0) $display("FAIL rmh_addr: got %h/%b want bfbffffc/0", bus.inst_sram_addr, bus.inst_sram_en); else passed++;
        total++; if (bus.inst_to_id !== 32'h0 || bus.if_to_id_bus[32] !== 1'b0) $display("FAIL rmh_zero: got %h/%b want 0/0", bus.inst_to_id, bus.if_to_id_bus[32]); else passed++;
        bus.stall = 2'b00;
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0000) $display("FAIL rmh_first: got %h want bfc00000", bus.inst_sram_addr); else passed++;
        tick();
        total++; if (bus.inst_sram_addr !== 32'hBFC0_0004) $display("FAIL rmh_second: got %h want bfc00004", bus.inst_sram_addr); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_branch();
        test_hold();
        test_pend_redirect();
        test_wrap();
        test_misalign();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
